serial_nibble_framer: RTL and testbench
=======================================

# serial_nibble_framer

Frame recovery stage that sits directly downstream of the 4-bit serial-in/parallel-out shifter. It watches the same serial line as the shifter and detects start and stop bits. At the correct cycle it captures the shifter's parallel word and queues validated nibbles in a small FIFO behind a valid/ready interface. Malformed frames are dropped and counted.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- ERR_CNT_W, 8: width of the saturating framing-error counter.
- clk  in  1  rising-edge clock, shared with the shifter.
- reset  in  1  reset, synchronous, active-high.
- din  in  1  serial line, the same signal the shifter samples.
- sipo_dout  in  4  shifter parallel output; the oldest bit is in [0].
- m_data  out  4  head-of-FIFO nibble.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts m_data.
- frame_err  out  1  one-cycle pulse on a bad frame.
- overflow  out  1  one-cycle pulse when a good frame is dropped because the FIFO is full.
- err_count  out  ERR_CNT_W  saturating count of bad frames.

## Operation
- Line format: idle low; start bit 1; data bits d1..d4, one per clock; optional parity bit; stop bit 0.
- FSM states:
  - IDLE: din=1 → DATA with bit_cnt=0.
  - DATA: bit_cnt increments each cycle. At bit_cnt=3 → PARITY if enabled, else STOP.
  - PARITY: see Configuration.
  - STOP: din=0 is a good frame → push the nibble, then IDLE. din=1 → frame_err, then RESYNC.
  - RESYNC: waits for din=0, then IDLE.
- Captured nibble is sipo_dout sampled in the STOP cycle, or in the PARITY cycle when parity is enabled. That value is {d4,d3,d2,d1}.
- Good frame with FIFO full and no pop in the same cycle: the nibble is dropped, overflow pulses, the FSM still returns to IDLE.
- Push while full is accepted if a pop (m_valid & m_ready) happens in the same cycle.
- Push and pop together at any occupancy: occupancy unchanged.
- Pointers wrap modulo DEPTH.
- err_count increments on each frame_err and holds at 2^ERR_CNT_W-1.
- Reset, including mid-frame or while data is queued:
  - FSM returns to IDLE and the FIFO empties.
  - m_valid=0, m_data=0, frame_err=0, overflow=0, err_count=0.

## Timing
- Start bit sampled at edge k. Data bits at edges k+1..k+4. sipo_dout holds the frame after edge k+4.
- Without parity:
  - Stop bit checked at edge k+5.
  - m_valid (push into an empty FIFO) rises after edge k+5.
  - frame_err or overflow is high in the cycle after edge k+5.
- With parity: each of the above moves one edge later, to k+6.
- No bypass: a push is visible on m_valid one cycle after it is accepted.
- Pop takes effect at the edge where m_valid & m_ready are both high. The next entry appears on the following cycle.
- Back-to-back frames are allowed: IDLE may accept a start bit at edge k+6 (k+7 with parity).

## Configuration
- Macro: SERIAL_NIBBLE_FRAMER_PARITY_EN.
- With the macro defined:
  - The PARITY state exists. At edge k+5, sipo_dout is captured into a hold register and even parity is checked (^data ^ din must be 0).
  - At STOP (k+6), a frame counts as bad if the stop bit is 1 or the parity check failed. Either case pulses frame_err.
  - A parity-failed frame with a good stop bit returns to IDLE, not RESYNC.
- Without the macro: no PARITY state and no hold register. The frame is 6 bits long.

## Structure
- Shared package (serial_nibble_pkg) holds:
  - the FSM state enum;
  - FRAME_BITS=4;
  - START_LVL=1 and STOP_LVL=0.
- One sub-module: nibble_fifo, a synchronous DEPTH×4 FIFO with push/pop/full/empty and a same-cycle push-on-pop rule.

## Test plan
- Good frame: after reset, din = 1,1,0,1,1,0 → m_valid rises after the 6th edge with m_data=4'hD. Pop with m_ready=1 → m_valid=0.
- Bad stop bit: din = 1,0,0,0,0,1 → frame_err pulses once, err_count=1, no push. FSM stays in RESYNC until din=0.
- Overflow: 5 good frames with m_ready=0 → 4 entries queued, overflow pulses on the 5th. Draining yields the first four nibbles in order.
- Full FIFO, push and pop together: FIFO full, a 5th frame's stop bit coincides with m_ready=1 → no overflow, occupancy stays 4, and the 5th nibble is the last one out.
- Reset mid-frame: reset after the 2nd data bit with 2 entries queued → the next cycle shows m_valid=0, err_count=0, FSM in IDLE. A following good frame 0x3 is received correctly.
- Parity (macro defined): data 0xD with parity bit 1 → accepted at edge k+6. The same frame with parity bit 0 → frame_err and err_count increments.

Source files
------------

// File: rtl/serial_nibble_pkg.sv
// Shared types and constants for the serial nibble framer.
// State enum, frame geometry and line levels.
package serial_nibble_pkg;
   localparam int   FRAME_BITS = 4;
   localparam int   CNT_W      = $clog2(FRAME_BITS);
   localparam logic START_LVL  = 1'b1;
   localparam logic STOP_LVL   = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DATA   = 3'd1,
`ifdef SERIAL_NIBBLE_FRAMER_PARITY_EN
      ST_PARITY = 3'd2,
`endif
      ST_STOP   = 3'd3,
      ST_RESYNC = 3'd4
   } state_t;
endpackage

// File: rtl/nibble_fifo.sv
// Synchronous DEPTH-entry FIFO; push visible on empty_o one cycle later, no bypass.
// A push while full is taken only when a pop happens in the same cycle.
module nibble_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          push_ok, pop_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);

   // Power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/serial_nibble_framer.sv
// Start/stop framer behind a 4-bit SIPO; queues good nibbles, counts bad frames.
// Optional even parity bit via SERIAL_NIBBLE_FRAMER_PARITY_EN; good frames drop with overflow when full.
module serial_nibble_framer
   import serial_nibble_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int ERR_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  din,
   input  logic [FRAME_BITS-1:0] sipo_dout,
   output logic [FRAME_BITS-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  frame_err,
   output logic                  overflow,
   output logic [ERR_CNT_W-1:0]  err_count
);
   state_t                state_q, state_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  frame_err_q, frame_err_d;
   logic                  overflow_q, overflow_d;
   logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic                  good_frame, bad_frame;
   logic [FRAME_BITS-1:0] push_data;
   logic                  fifo_full, fifo_empty;
`ifdef SERIAL_NIBBLE_FRAMER_PARITY_EN
   logic [FRAME_BITS-1:0] hold_q, hold_d;
   logic                  par_err_q, par_err_d;
`endif

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      good_frame = 1'b0;
      bad_frame  = 1'b0;
`ifdef SERIAL_NIBBLE_FRAMER_PARITY_EN
      hold_d     = hold_q;
      par_err_d  = par_err_q;
      push_data  = hold_q;
`else
      push_data  = sipo_dout;
`endif
      case (state_q)
         ST_IDLE: begin
            if (din == START_LVL) begin
               state_d   = ST_DATA;
               bit_cnt_d = '0;
            end
         end
         ST_DATA: begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
`ifdef SERIAL_NIBBLE_FRAMER_PARITY_EN
               state_d = ST_PARITY;
`else
               state_d = ST_STOP;
`endif
            end
         end
`ifdef SERIAL_NIBBLE_FRAMER_PARITY_EN
         // The shifter still holds the nibble here; next edge shifts parity in.
         ST_PARITY: begin
            hold_d    = sipo_dout;
            par_err_d = ^sipo_dout ^ din;
            state_d   = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (din != STOP_LVL) begin
               bad_frame = 1'b1;
               state_d   = ST_RESYNC;
`ifdef SERIAL_NIBBLE_FRAMER_PARITY_EN
            end else if (par_err_q) begin
               bad_frame = 1'b1;
               state_d   = ST_IDLE;
`endif
            end else begin
               good_frame = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         ST_RESYNC: begin
            if (din == STOP_LVL) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign frame_err_d = bad_frame;
   assign overflow_d  = good_frame & fifo_full & ~(m_valid & m_ready);
   assign err_cnt_d   = (bad_frame && (err_cnt_q != '1)) ? err_cnt_q + ERR_CNT_W'(1)
                                                         : err_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
         err_cnt_q   <= '0;
`ifdef SERIAL_NIBBLE_FRAMER_PARITY_EN
         hold_q      <= '0;
         par_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
         err_cnt_q   <= err_cnt_d;
`ifdef SERIAL_NIBBLE_FRAMER_PARITY_EN
         hold_q      <= hold_d;
         par_err_q   <= par_err_d;
`endif
      end
   end

   nibble_fifo #(
      .DEPTH (DEPTH),
      .W     (FRAME_BITS)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (good_frame),
      .push_data_i (push_data),
      .pop_i       (m_ready),
      .head_o      (m_data),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign m_valid   = ~fifo_empty;
   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;
   assign err_count = err_cnt_q;
endmodule

// File: tb/tb_serial_nibble_framer.sv
// Randomized bench for serial_nibble_framer with a frame-level scoreboard.
// Parity frames are generated when SERIAL_NIBBLE_FRAMER_PARITY_EN is defined.
module tb_serial_nibble_framer;
   localparam int DEPTH     = 4;
   localparam int ERR_CNT_W = 8;
   localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;
`ifdef SERIAL_NIBBLE_FRAMER_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 din = 1'b0;
   logic                 m_ready = 1'b0;
   logic [3:0]           sipo_dout = 4'h0;
   logic [3:0]           m_data;
   logic                 m_valid, frame_err, overflow;
   logic [ERR_CNT_W-1:0] err_count;

   serial_nibble_framer #(.DEPTH(DEPTH), .ERR_CNT_W(ERR_CNT_W)) dut (
      .clk(clk), .reset(reset), .din(din), .sipo_dout(sipo_dout),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .frame_err(frame_err), .overflow(overflow), .err_count(err_count)
   );

   always #5 clk = ~clk;

   // Upstream shifter: oldest bit ends up in [0].
   always @(posedge clk) sipo_dout <= {din, sipo_dout[3:1]};

   int         total = 0;
   int         bad = 0;
   int         rdy_mode = 0;
   logic       stop_flag = 1'b0;
   logic [3:0] cur_nib = 4'h0;
   logic       cur_bad = 1'b0;

   logic [3:0] exp_q[$];
   int         err_m = 0;
   logic       exp_ferr = 1'b0, exp_ovf = 1'b0;
   logic       armed = 1'b0, post_rst = 1'b0;

   // Frame-level model: at the stop-bit edge decide the frame's fate.
   always @(posedge clk) begin
      exp_ferr <= 1'b0;
      exp_ovf  <= 1'b0;
      if (reset) begin
         exp_q.delete();
         err_m    <= 0;
         armed    <= 1'b1;
         post_rst <= 1'b1;
      end else begin
         post_rst <= 1'b0;
         if (stop_flag) begin
            if (cur_bad) begin
               exp_ferr <= 1'b1;
               if (err_m < ERR_MAX) err_m <= err_m + 1;
            end else if (exp_q.size() < DEPTH) begin
               exp_q.push_back(cur_nib);
            end else begin
               exp_ovf <= 1'b1;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (armed) begin
         chk("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0)
            chk("m_data", 32'(m_data), 32'(exp_q[0]));
         else if (post_rst)
            chk("m_data_reset", 32'(m_data), 32'd0);
         chk("frame_err", 32'(frame_err), 32'(exp_ferr));
         chk("overflow", 32'(overflow), 32'(exp_ovf));
         chk("err_count", 32'(err_count), 32'(err_m));
         // Handshake seen here completes at the coming rising edge.
         if (m_valid && m_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
   end

   function automatic logic pick();
      case (rdy_mode)
         0:       return 1'b0;
         1:       return 1'b1;
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   task automatic drive(input logic b, input logic rdy, input logic stp,
                        input logic [3:0] nib, input logic bd);
      @(posedge clk);
      #1;
      din       = b;
      m_ready   = rdy;
      stop_flag = stp;
      cur_nib   = nib;
      cur_bad   = bd;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, pick(), 1'b0, 4'h0, 1'b0);
   endtask

   task automatic ones(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, pick(), 1'b0, 4'h0, 1'b0);
   endtask

   // stop_rdy < 0 uses the current ready mode on the stop-bit cycle.
   task automatic send_frame(input logic [3:0] nib, input logic sb, input logic pb,
                             input int stop_rdy);
      logic fbad;
      logic r;
      fbad = sb | (PAR & pb);
      drive(1'b1, pick(), 1'b0, 4'h0, 1'b0);
      for (int i = 0; i < 4; i++) drive(nib[i], pick(), 1'b0, 4'h0, 1'b0);
      if (PAR) drive(^nib ^ pb, pick(), 1'b0, 4'h0, 1'b0);
      r = (stop_rdy < 0) ? pick() : stop_rdy[0];
      drive(sb, r, 1'b1, nib, fbad);
   endtask

   initial begin
      logic [3:0] nib;
      logic       sb, pb;

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      idle(2);

      // Good frame 0xD, then pop it.
      rdy_mode = 0;
      send_frame(4'hD, 1'b0, 1'b0, -1);
      idle(1);
      rdy_mode = 1;
      idle(2);

      // Bad stop bit, line held high in RESYNC before returning low.
      send_frame(4'h0, 1'b1, 1'b0, -1);
      ones(3);
      idle(2);

      // Reset mid-frame with two entries queued.
      rdy_mode = 0;
      send_frame(4'h5, 1'b0, 1'b0, -1);
      idle(1);
      send_frame(4'hA, 1'b0, 1'b0, -1);
      idle(1);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
      @(posedge clk);
      #1 reset = 1'b1; din = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      idle(1);
      rdy_mode = 1;
      send_frame(4'h3, 1'b0, 1'b0, -1);
      idle(3);

      // Overflow: five frames with consumer stalled, then drain.
      rdy_mode = 0;
      for (int f = 0; f < 5; f++) begin
         send_frame(4'(f + 6), 1'b0, 1'b0, -1);
         idle(1);
      end
      rdy_mode = 1;
      idle(6);

      // Full FIFO with pop coinciding with the fifth stop bit.
      rdy_mode = 0;
      for (int f = 0; f < 4; f++) send_frame(4'(f + 1), 1'b0, 1'b0, -1);
      send_frame(4'hE, 1'b0, 1'b0, 1);
      idle(1);
      rdy_mode = 1;
      idle(6);

      if (PAR) begin
         send_frame(4'hD, 1'b0, 1'b0, -1);
         idle(1);
         send_frame(4'hD, 1'b0, 1'b1, -1);
         idle(2);
      end

      // Randomized traffic, back-to-back frames allowed after a good stop.
      rdy_mode = 2;
      for (int f = 0; f < 150; f++) begin
         nib = 4'($urandom_range(0, 15));
         sb  = ($urandom_range(0, 7) == 0);
         pb  = ($urandom_range(0, 7) == 0);
         send_frame(nib, sb, pb, -1);
         if (sb) begin
            ones($urandom_range(0, 2));
            idle($urandom_range(1, 2));
         end else begin
            idle($urandom_range(0, 2));
         end
      end
      rdy_mode = 1;
      idle(6);

      // Drive the error counter into saturation.
      for (int f = 0; f < ERR_MAX + 5; f++) begin
         send_frame(4'($urandom_range(0, 15)), 1'b1, 1'b0, -1);
         idle(1);
      end
      send_frame(4'h9, 1'b0, 1'b0, -1);
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
